// File: rtl/gpio_checker_pkg.sv
// Shared types and helpers for the trigger/rotating-GPIO checker.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package gpio_checker_pkg;

    // Widest GPIO bus the helper functions handle.
    localparam int unsigned ROT_MAX_W = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_PULSE = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_TIMEOUT      = 2'd1,
        ERR_WRONG_VALUE  = 2'd2,
        ERR_EXTRA_CHANGE = 2'd3
    } err_t;

    // Rotate the low w bits of v left by one; bits at and above w come back as 0.
    function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] v,
                                                  input int unsigned w);
        logic [ROT_MAX_W-1:0] mask;
        mask = {ROT_MAX_W{1'b1}} >> (ROT_MAX_W - w);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

    // True when exactly one bit is set (all-zero is not one-hot).
    function automatic logic is_onehot(input logic [ROT_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - 1)) == '0);
    endfunction

endpackage

// File: rtl/gpio_trigger_checker_if.sv
// Control/status and GPIO-loop signals of the trigger checker.
// Latency: none (wiring only).
// Backpressure: none; start is a one-cycle request ignored while busy.
interface gpio_trigger_checker_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [7:0]       num_triggers;
    logic [WIDTH-1:0] gpio_in;       // driven by the rotating GPIO responder
    logic             trigger;
    logic             busy;
    logic             done;
    logic [7:0]       pass_count;
    logic [7:0]       error_count;
    logic [1:0]       last_error;

    // Software plus responder side: drives requests and the observed GPIO.
    modport master (
        output start, num_triggers, gpio_in,
        input  trigger, busy, done, pass_count, error_count, last_error
    );

    // Checker side.
    modport slave (
        input  start, num_triggers, gpio_in,
        output trigger, busy, done, pass_count, error_count, last_error
    );
endinterface

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for the observed GPIO bus.
// Latency: 2 cycles from d to q.
// Backpressure: none; samples every cycle.
module gpio_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; reset clears both stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/gpio_trigger_checker.sv
// Drives trigger pulses into the rotating GPIO block and checks one left rotation per pulse.
// Latency: trigger rises 2 cycles after start; counters update the cycle after a detection.
// Backpressure: start is ignored while busy and in the DONE cycle. Macro GPIO_CHECKER_SYNC_EN adds a 2-flop input synchronizer.
module gpio_trigger_checker
    import gpio_checker_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 4,
    parameter int TIMEOUT   = 16
) (
    input logic                  clk,
    input logic                  reset,
    gpio_trigger_checker_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] gpio_s;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_rot;
    logic [7:0]       remaining_q;
    logic [TW-1:0]    timer_q;
    logic [PW-1:0]    pcnt_q;
    logic [GW-1:0]    gcnt_q;
    logic             responded_q;
    logic [7:0]       pass_q;
    logic [7:0]       err_q;
    err_t             last_err_q;
    logic             trigger_q;
    logic             busy_q;
    logic             done_q;

    logic             changed;
    logic             rot_ok;
    logic             init_ok;
    logic             start_run;
    logic             inc_pass;
    logic             inc_err;
    err_t             err_code;
    logic             load_prev;
    logic             set_resp;
    logic             clr_pulse;
    logic             dec_rem;

`ifdef GPIO_CHECKER_SYNC_EN
    gpio_sync #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.gpio_in),
        .q     (gpio_s)
    );
`else
    assign gpio_s = bus.gpio_in;
`endif

    assign prev_rot = WIDTH'(rotl(ROT_MAX_W'(prev_q), WIDTH));
    assign changed  = (gpio_s != prev_q);
    assign rot_ok   = (gpio_s == prev_rot);
    assign init_ok  = is_onehot(ROT_MAX_W'(gpio_s));

    // Next-state decode and per-cycle event strobes for the datapath.
    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        inc_pass  = 1'b0;
        inc_err   = 1'b0;
        err_code  = ERR_NONE;
        load_prev = 1'b0;
        set_resp  = 1'b0;
        clr_pulse = 1'b0;
        dec_rem   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    start_run = 1'b1;
                    state_d   = (bus.num_triggers == 8'd0) ? S_DONE : S_INIT;
                end
            end
            S_INIT: begin
                load_prev = 1'b1;
                if (!init_ok) begin
                    inc_err  = 1'b1;
                    err_code = ERR_WRONG_VALUE;
                    state_d  = S_DONE;
                end else begin
                    clr_pulse = 1'b1;
                    state_d   = S_PULSE;
                end
            end
            S_PULSE: begin
                if (changed) begin
                    load_prev = 1'b1;
                    if (responded_q) begin
                        inc_err  = 1'b1;
                        err_code = ERR_EXTRA_CHANGE;
                    end else begin
                        set_resp = 1'b1;
                        if (rot_ok) begin
                            inc_pass = 1'b1;
                        end else begin
                            inc_err  = 1'b1;
                            err_code = ERR_WRONG_VALUE;
                        end
                    end
                end
                if (pcnt_q == PW'(PULSE_LEN - 1)) begin
                    state_d = (responded_q || changed) ? S_GAP : S_WAIT;
                end
            end
            S_WAIT: begin
                // A change in the timeout cycle still counts as the response.
                if (changed) begin
                    load_prev = 1'b1;
                    set_resp  = 1'b1;
                    if (rot_ok) begin
                        inc_pass = 1'b1;
                    end else begin
                        inc_err  = 1'b1;
                        err_code = ERR_WRONG_VALUE;
                    end
                    state_d = S_GAP;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    inc_err  = 1'b1;
                    err_code = ERR_TIMEOUT;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (changed) begin
                    load_prev = 1'b1;
                    inc_err   = 1'b1;
                    err_code  = ERR_EXTRA_CHANGE;
                end
                if (gcnt_q == GW'(GAP_LEN - 1)) begin
                    dec_rem = 1'b1;
                    if (remaining_q == 8'd1) begin
                        state_d = S_DONE;
                    end else begin
                        clr_pulse = 1'b1;
                        state_d   = S_PULSE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, registered outputs, timers and saturating result counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            pcnt_q      <= '0;
            gcnt_q      <= '0;
            responded_q <= 1'b0;
            pass_q      <= '0;
            err_q       <= '0;
            last_err_q  <= ERR_NONE;
            trigger_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            trigger_q <= (state_d == S_PULSE);
            busy_q    <= (state_d inside {S_INIT, S_PULSE, S_WAIT, S_GAP});
            done_q    <= (state_d == S_DONE);

            pcnt_q <= (state_q == S_PULSE) ? pcnt_q + PW'(1) : '0;
            gcnt_q <= (state_q == S_GAP) ? gcnt_q + GW'(1) : '0;

            if (clr_pulse) begin
                timer_q     <= '0;
                responded_q <= 1'b0;
            end else begin
                if (state_q == S_PULSE || state_q == S_WAIT) begin
                    timer_q <= timer_q + TW'(1);
                end
                if (set_resp) begin
                    responded_q <= 1'b1;
                end
            end

            if (load_prev) begin
                prev_q <= gpio_s;
            end

            if (start_run) begin
                remaining_q <= bus.num_triggers;
            end else if (dec_rem) begin
                remaining_q <= remaining_q - 8'd1;
            end

            if (start_run) begin
                pass_q     <= '0;
                err_q      <= '0;
                last_err_q <= ERR_NONE;
            end else begin
                if (inc_pass && pass_q != 8'hFF) begin
                    pass_q <= pass_q + 8'd1;
                end
                if (inc_err) begin
                    last_err_q <= err_code;
                    if (err_q != 8'hFF) begin
                        err_q <= err_q + 8'd1;
                    end
                end
            end
        end
    end

    assign bus.trigger     = trigger_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass_count  = pass_q;
    assign bus.error_count = err_q;
    assign bus.last_error  = last_err_q;

endmodule

// File: tb/tb_gpio_trigger_checker.sv
// Bench for gpio_trigger_checker with a behavioural rotating-GPIO responder.
// Latency: responder answers a configurable number of cycles after each trigger rise.
// Backpressure: none; runs are issued one at a time.
module tb_gpio_trigger_checker;

    typedef struct {
        logic [7:0] n;
        logic [4:0] init;
        int         delay;
        bit         wrong;
        int         extra;
        int         exp_pass;
        int         exp_err;
        int         exp_last;
        int         exp_trig;
    } vec_t;

    typedef struct {
        int pass;
        int err;
        int last;
        int trig;
    } exp_t;

    logic clk;
    logic reset;

    gpio_trigger_checker_if #(.WIDTH(5)) bus ();

    gpio_trigger_checker #(
        .WIDTH(5), .PULSE_LEN(4), .GAP_LEN(4), .TIMEOUT(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    vec_t vecs[12];

    // Responder configuration (written by the main process only).
    logic [4:0] cfg_init  = 5'b00001;
    int         cfg_delay = 0;
    bit         cfg_wrong = 1'b0;
    int         cfg_extra = 0;
    int         cfg_seq   = 0;

    // Responder state (written by the responder process only).
    int         seen_seq   = -1;
    logic [4:0] gpio       = 5'b0;
    bit         first_resp = 1'b0;
    bit         r_trig_d   = 1'b0;
    int         k          = 1000;

    // Monitor state (written by the monitor process only).
    int cyc       = 0;
    int rises     = 0;
    int rise_cyc  = 0;
    int prev_rise = 0;
    bit m_trig_d  = 1'b0;

    function automatic logic [4:0] rot1(input logic [4:0] v);
        return {v[3:0], v[4]};
    endfunction

    // Rotating GPIO responder: k counts cycles since the last trigger rise.
    always @(negedge clk) begin
        if (cfg_seq != seen_seq) begin
            seen_seq   = cfg_seq;
            gpio       = cfg_init;
            first_resp = 1'b1;
            k          = 1000;
        end else begin
            if (bus.trigger && !r_trig_d) k = 0;
            else if (k < 100000) k++;
            if (cfg_delay != 0 && k == cfg_delay) begin
                if (cfg_wrong && first_resp) gpio = rot1(rot1(gpio));
                else gpio = rot1(gpio);
                first_resp = 1'b0;
            end
            if (cfg_extra != 0 && k == cfg_extra) gpio = rot1(gpio);
        end
        r_trig_d    = bus.trigger;
        bus.gpio_in = gpio;
    end

    // Counts trigger pulses and remembers when the last two began.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_trig_d = 1'b0;
        end else begin
            if (bus.trigger && !m_trig_d) begin
                rises++;
                prev_rise = rise_cyc;
                rise_cyc  = cyc;
            end
            m_trig_d = bus.trigger;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic configure(input logic [4:0] init, input int d, input bit w, input int x);
        cfg_init  = init;
        cfg_delay = d;
        cfg_wrong = w;
        cfg_extra = x;
        cfg_seq++;
        repeat (2) @(negedge clk);
    endtask

    // Issue a one-cycle start; returns at the negedge of the cycle after start.
    task automatic start_run(input logic [7:0] n, input bit push,
                             input int ep, input int ee, input int el, input int et);
        exp_t e;
        if (push) begin
            e.pass = ep; e.err = ee; e.last = el; e.trig = rises + et;
            sb.push_back(e);
        end
        bus.start        = 1'b1;
        bus.num_triggers = n;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done, then pop the scoreboard and compare.
    task automatic wait_done(input string tag);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_done: got no done expected done within 400 cycles", tag);
            sb.delete();
        end else if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_done: got done expected no pending run", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pass"}, bus.pass_count, e.pass);
            chk({tag, "_err"},  bus.error_count, e.err);
            chk({tag, "_last"}, bus.last_error, e.last);
            chk({tag, "_trig"}, rises, e.trig);
        end
    endtask

    initial begin
        int base;
        bit hit;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.num_triggers = 8'd0;

        vecs[0]  = '{8'd3, 5'b10000, 1,  1'b0, 0, 3, 0, 0, 3};  // good run with wrap
        vecs[1]  = '{8'd2, 5'b00100, 0,  1'b0, 0, 0, 2, 1, 2};  // silent responder
        vecs[2]  = '{8'd2, 5'b00001, 1,  1'b1, 0, 1, 1, 2, 2};  // wrong value then good
        vecs[3]  = '{8'd2, 5'b00001, 1,  1'b0, 5, 2, 2, 3, 2};  // extra change in GAP
        vecs[4]  = '{8'd2, 5'b00010, 6,  1'b0, 0, 2, 0, 0, 2};  // response during WAIT
        vecs[5]  = '{8'd1, 5'b00001, 16, 1'b0, 0, 1, 0, 0, 1};  // response on timeout cycle
        vecs[6]  = '{8'd1, 5'b00001, 17, 1'b0, 0, 0, 2, 3, 1};  // one cycle too late
        vecs[7]  = '{8'd1, 5'b00001, 4,  1'b0, 0, 1, 0, 0, 1};  // first WAIT cycle
        vecs[8]  = '{8'd1, 5'b01000, 1,  1'b0, 2, 1, 1, 3, 1};  // second change in PULSE
        vecs[9]  = '{8'd0, 5'b00001, 1,  1'b0, 0, 0, 0, 0, 0};  // zero triggers
        vecs[10] = '{8'd3, 5'b00000, 1,  1'b0, 0, 0, 1, 2, 0};  // all-zero initial
        vecs[11] = '{8'd1, 5'b00011, 1,  1'b0, 0, 0, 1, 2, 0};  // two-hot initial

        repeat (3) @(negedge clk);
        chk("rst_trigger", bus.trigger, 0);
        chk("rst_busy",    bus.busy, 0);
        chk("rst_done",    bus.done, 0);
        chk("rst_pass",    bus.pass_count, 0);
        chk("rst_err",     bus.error_count, 0);
        chk("rst_last",    bus.last_error, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            configure(vecs[i].init, vecs[i].delay, vecs[i].wrong, vecs[i].extra);
            start_run(vecs[i].n, 1'b1, vecs[i].exp_pass, vecs[i].exp_err,
                      vecs[i].exp_last, vecs[i].exp_trig);
            wait_done($sformatf("v%0d", i));
            repeat (2) @(negedge clk);
        end

        // Start-to-trigger latency and pulse period.
        configure(5'b00001, 1, 1'b0, 0);
        start_run(8'd2, 1'b1, 2, 0, 0, 2);
        chk("lat_busy_t1", bus.busy, 1);
        chk("lat_trig_t1", bus.trigger, 0);
        @(negedge clk);
        chk("lat_trig_t2", bus.trigger, 1);
        wait_done("lat");
        chk("pulse_period", rise_cyc - prev_rise, 8);
        repeat (2) @(negedge clk);

        // Zero triggers: done in the cycle after start, busy never set.
        configure(5'b00001, 1, 1'b0, 0);
        start_run(8'd0, 1'b1, 0, 0, 0, 0);
        chk("n0_done_t1", bus.done, 1);
        chk("n0_busy_t1", bus.busy, 0);
        wait_done("n0");
        repeat (2) @(negedge clk);

        // Bad initial value: done two cycles after start.
        configure(5'b00000, 1, 1'b0, 0);
        start_run(8'd2, 1'b1, 0, 1, 2, 0);
        chk("bad_done_t1", bus.done, 0);
        chk("bad_busy_t1", bus.busy, 1);
        @(negedge clk);
        chk("bad_done_t2", bus.done, 1);
        wait_done("bad");
        repeat (2) @(negedge clk);

        // Start while busy and start in the DONE cycle are both ignored.
        configure(5'b00001, 1, 1'b0, 0);
        start_run(8'd2, 1'b1, 2, 0, 0, 2);
        repeat (5) @(negedge clk);
        bus.start        = 1'b1;
        bus.num_triggers = 8'd9;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("busy_start");
        base             = rises;
        bus.start        = 1'b1;
        bus.num_triggers = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_start_busy", bus.busy, 0);
        chk("done_start_pass", bus.pass_count, 2);
        chk("done_start_trig", rises, base);
        repeat (2) @(negedge clk);

        // Reset in the middle of the second pulse, then a clean rerun.
        configure(5'b00001, 1, 1'b0, 0);
        base = rises;
        start_run(8'd3, 1'b0, 0, 0, 0, 0);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rises >= base + 2 && bus.trigger) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_second_pulse_seen", hit, 1);
        chk("mid_pass_before", bus.pass_count, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_trigger", bus.trigger, 0);
        chk("mid_busy",    bus.busy, 0);
        chk("mid_pass",    bus.pass_count, 0);
        chk("mid_err",     bus.error_count, 0);
        repeat (2) @(negedge clk);
        configure(5'b00001, 1, 1'b0, 0);
        start_run(8'd2, 1'b1, 2, 0, 0, 2);
        wait_done("rerun");
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
